valu_issue_ctrl: RTL and testbench

Issue/sequencing controller for the vector ALU in the Execute stage. It accepts one vector operation at a time over a valid/ready handshake and registers the opcode and operands. It drives the ALU selector and operand buses stable for the op-specific number of cycles, then captures the ALU result and presents it to writeback over a second valid/ready handshake. It also supports a pipeline flush and counts completed operations.

---
 rtl/valu_issue_ctrl.sv | 96 +++++++++
 tb/tb_valu_issue_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/valu_issue_ctrl.sv
// valu_issue_ctrl: issues one vector op at a time to the ALU, holds operands for the
// op latency, then hands the captured result to writeback over valid/ready.
module valu_issue_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int LANES         = 6,
    parameter int SELECTOR_SIZE = 3,
    parameter int DEST_WIDTH    = 4,
    parameter int MUL_LATENCY   = 2,
    parameter int DIV_LATENCY   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SELECTOR_SIZE-1:0]      in_op,
    input  logic [DEST_WIDTH-1:0]         in_dest,
    input  logic [DATA_WIDTH*LANES-1:0]   in_operand1,
    input  logic [DATA_WIDTH*LANES-1:0]   in_operand2,
    output logic [SELECTOR_SIZE-1:0]      alu_selector,
    output logic [DATA_WIDTH*LANES-1:0]   alu_operand1,
    output logic [DATA_WIDTH*LANES-1:0]   alu_operand2,
    input  logic [DATA_WIDTH*LANES-1:0]   alu_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*LANES-1:0]   out_data,
    output logic [DEST_WIDTH-1:0]         out_dest,
    output logic                          busy,
    output logic [15:0]                   op_count
);
    localparam int MAXL = DIV_LATENCY > MUL_LATENCY ? DIV_LATENCY : MUL_LATENCY;
    localparam int CW   = MAXL > 1 ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           cnt, lat_m1;
    logic [DEST_WIDTH-1:0]   tag;
    logic                    accept;

    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign lat_m1   = in_op == SELECTOR_SIZE'(2) ? CW'(DIV_LATENCY - 1) :
                      (in_op == SELECTOR_SIZE'(3) || in_op == SELECTOR_SIZE'(4)) ? CW'(MUL_LATENCY - 1) : '0;

    always_comb begin
        state_next = flush ? IDLE :
                     accept ? EXEC :
                     (state == EXEC && cnt == '0) ? DONE :
                     (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_selector <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            tag          <= '0;
            cnt          <= '0;
            out_data     <= '0;
            out_dest     <= '0;
            out_valid    <= 1'b0;
            op_count     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            // accept only happens in IDLE/DONE, so it never collides with the EXEC countdown
            if (accept) begin
                alu_selector <= in_op;
                alu_operand1 <= in_operand1;
                alu_operand2 <= in_operand2;
                tag          <= in_dest;
                cnt          <= lat_m1;
            end else if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    out_data  <= alu_result;
                    out_dest  <= tag;
                    out_valid <= 1'b1;
                end
            end
            if (state == DONE && out_ready) begin
                op_count  <= op_count + 16'd1;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_valu_issue_ctrl.sv
// tb_valu_issue_ctrl: directed vectors against valu_issue_ctrl with a per-lane ALU stand-in.
module tb_valu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  in_op, alu_selector;
    logic [3:0]  in_dest, out_dest;
    logic [47:0] in_operand1, in_operand2, alu_operand1, alu_operand2, alu_result, out_data;
    logic [15:0] op_count;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    valu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dest(in_dest),
        .in_operand1(in_operand1), .in_operand2(in_operand2),
        .alu_selector(alu_selector), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest), .busy(busy), .op_count(op_count)
    );

    function automatic logic [47:0] alu_f(input logic [2:0] s, input logic [47:0] x, input logic [47:0] y);
        logic [47:0] r;
        logic [7:0]  a, b;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            a = x[i*8 +: 8];
            b = y[i*8 +: 8];
            r[i*8 +: 8] = s == 3'd0 ? a + b :
                          s == 3'd2 ? (b != 0 ? a / b : 8'h00) :
                          (s == 3'd3 || s == 3'd4) ? 8'(a * b) :
                          s == 3'd6 ? b :
                          s == 3'd7 ? a ^ b : a - b;
        end
        return r;
    endfunction

    assign alu_result = alu_f(alu_selector, alu_operand1, alu_operand2);

    function automatic logic [47:0] rep(input logic [7:0] b);
        return {6{b}};
    endfunction

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] dest, input logic [47:0] a, input logic [47:0] b);
        in_valid = 1'b1; in_op = op; in_dest = dest; in_operand1 = a; in_operand2 = b;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_dest = '0;
        in_operand1 = '0; in_operand2 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // add, one-cycle latency
        out_ready = 1'b1;
        issue(3'd0, 4'd3, rep(8'h10), rep(8'h05));
        tick(); in_valid = 1'b0;
        check("add_busy", busy, 1);
        check("add_out_valid_early", out_valid, 0);
        check("add_operand1", alu_operand1, rep(8'h10));
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_out_data", out_data, 48'h151515151515);
        check("add_out_dest", out_dest, 3);
        check("add_in_ready_handoff", in_ready, 1);
        tick();
        check("add_op_count", op_count, 1);
        check("add_idle", busy, 0);

        // divide, four-cycle latency
        issue(3'd2, 4'd5, rep(8'h40), rep(8'h08));
        tick(); in_valid = 1'b0;
        check("div_in_ready_0", in_ready, 0);
        check("div_valid_0", out_valid, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("div_valid_wait", out_valid, 0);
            check("div_sel", alu_selector, 3'd2);
            check("div_op2_stable", alu_operand2, rep(8'h08));
            check("div_in_ready", in_ready, 0);
        end
        tick();
        check("div_out_valid", out_valid, 1);
        check("div_out_data", out_data, 48'h080808080808);
        check("div_out_dest", out_dest, 5);
        tick();
        check("div_op_count", op_count, 2);

        // backpressure then back-to-back accept
        out_ready = 1'b0;
        issue(3'd0, 4'd7, rep(8'h01), rep(8'h02));
        tick(); in_valid = 1'b0;
        tick();
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, rep(8'h03));
            check("bp_hold_dest", out_dest, 7);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        issue(3'd4, 4'd9, rep(8'h03), rep(8'h04));
        #1;
        check("b2b_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        check("b2b_op_count", op_count, 3);
        check("b2b_valid_drop", out_valid, 0);
        check("b2b_busy", busy, 1);
        check("b2b_sel", alu_selector, 3'd4);
        tick();
        check("mul_valid_wait", out_valid, 0);
        tick();
        check("mul_out_valid", out_valid, 1);
        check("mul_out_data", out_data, rep(8'h0C));
        check("mul_out_dest", out_dest, 9);
        tick();
        check("mul_op_count", op_count, 4);

        // flush during divide EXEC
        issue(3'd2, 4'd2, rep(8'h40), rep(8'h08));
        tick(); in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("flush_no_valid", out_valid, 0);
        end
        check("flush_op_count", op_count, 4);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd0;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_no_accept", busy, 0);
        flush = 1'b0; in_valid = 1'b0;

        // flush in DONE with out_ready high
        out_ready = 1'b0;
        issue(3'd0, 4'd1, rep(8'h10), rep(8'h05));
        tick(); in_valid = 1'b0;
        tick();
        check("fd_valid", out_valid, 1);
        out_ready = 1'b1; flush = 1'b1;
        tick(); flush = 1'b0;
        check("fd_valid_drop", out_valid, 0);
        check("fd_op_count", op_count, 4);
        check("fd_busy", busy, 0);
        check("fd_data_kept", out_data, rep(8'h15));

        // asynchronous reset mid-EXEC
        issue(3'd2, 4'd4, rep(8'h40), rep(8'h08));
        tick(); in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", alu_selector, 0);
        check("arst_op1", alu_operand1, 0);
        check("arst_busy", busy, 0);
        check("arst_op_count", op_count, 0);
        check("arst_valid", out_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        issue(3'd6, 4'd6, rep(8'h11), 48'hAABBCCDDEEFF);
        tick(); in_valid = 1'b0;
        tick();
        check("pass_valid", out_valid, 1);
        check("pass_data", out_data, 48'hAABBCCDDEEFF);
        check("pass_dest", out_dest, 6);
        tick();
        check("pass_op_count", op_count, 1);

        // opcode 111 single cycle, opcode 011 two cycles
        issue(3'd7, 4'd8, rep(8'h0F), rep(8'h33));
        tick(); in_valid = 1'b0;
        tick();
        check("op7_valid", out_valid, 1);
        check("op7_data", out_data, rep(8'h3C));
        tick();
        issue(3'd3, 4'd10, rep(8'h05), rep(8'h03));
        tick(); in_valid = 1'b0;
        tick();
        check("fmul_valid_wait", out_valid, 0);
        tick();
        check("fmul_valid", out_valid, 1);
        check("fmul_data", out_data, rep(8'h0F));
        tick();
        check("final_op_count", op_count, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
